// File: rtl/flash_cmd_seq_if.sv
// Host request/response bus plus SPI pins for flash_cmd_seq.
// slave  : the sequencer (consumes req/op/addr/wdata/so, drives status and SPI outputs)
// master : host and flash side (drives req/op/addr/wdata/so, observes the rest)
interface flash_cmd_seq_if;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 8;

  logic              req;
  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              sclk;
  logic              cs;
  logic              si;
  logic              so;
  logic              wp;
  logic              hold;

  modport slave (
    input  req, op, addr, wdata, so,
    output busy, done, err, rdata, sclk, cs, si, wp, hold
  );

  modport master (
    output req, op, addr, wdata, so,
    input  busy, done, err, rdata, sclk, cs, si, wp, hold
  );
endinterface

// File: rtl/flash_cmd_seq.sv
// SPI NOR command sequencer: read byte, page-program byte and sector erase,
// with write-enable preamble and status polling until WIP clears or times out.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   bus (slave) : req/op/addr/wdata in, busy/done/err/rdata out,
//                 SPI mode-0 pins sclk/cs/si out, so in, wp/hold tied high
module flash_cmd_seq #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned POLL_MAX = 65535
) (
  input logic            clk,
  input logic            rst_n,
  flash_cmd_seq_if.slave bus
);
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned FRM_W  = 40;
  localparam int unsigned BIT_W  = 6;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned GAP_MIN = (CS_GAP == 0) ? 1 : CS_GAP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_MIN - 1);
  localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'h20;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {S_IDLE, S_WREN, S_GAP, S_XFER, S_POLL, S_FIN} state_t;
  // F_WAIT: CS high, no frame in flight; others walk one SPI frame
  typedef enum logic [1:0] {F_WAIT, F_LO, F_HI, F_TAIL} fphase_t;

  state_t             state;
  state_t             gap_next;
  fphase_t            fphase;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bits_left;
  logic [FRM_W-1:0]   tx_sh;
  logic [7:0]         rx_sh;
  logic [CNT_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   poll_cnt;
  logic [1:0]         op_q;
  logic [23:0]        addr_q;
  logic [7:0]         wdata_q;
  logic               err_q;
  logic               busy;
  logic               done;
  logic               err;
  logic [7:0]         rdata;
  logic               sclk;
  logic               cs;
  logic               si;

  state_t             frm_kind_c;
  logic               gap_ok_c;
  logic               frm_go_c;
  logic [FRM_W-1:0]   frm_word_c;
  logic [BIT_W-1:0]   frm_bits_c;
  logic [CNT_W-1:0]   poll_nxt_c;

  // Frame launch decision and the bit pattern of the frame about to start
  always_comb begin
    frm_kind_c = (state == S_GAP) ? gap_next : state;
    // gap_cnt counts completed CS-high cycles, so this is the last one of the gap
    gap_ok_c   = cs && (gap_cnt >= GAP_LAST);
    frm_go_c   = 1'b0;
    if ((fphase == F_WAIT) && (state inside {S_WREN, S_XFER, S_POLL, S_GAP}))
      frm_go_c = gap_ok_c;
    frm_word_c = '0;
    frm_bits_c = BIT_W'(8);
    case (frm_kind_c)
      S_WREN: begin
        frm_word_c = {CMD_WREN, 32'h0};
        frm_bits_c = BIT_W'(8);
      end
      S_POLL: begin
        frm_word_c = {CMD_RDSR, 32'h0};
        frm_bits_c = BIT_W'(16);
      end
      S_XFER: begin
        case (op_q)
          2'd0: begin
            frm_word_c = {CMD_READ, addr_q, 8'h00};
            frm_bits_c = BIT_W'(40);
          end
          2'd1: begin
            frm_word_c = {CMD_PP, addr_q, wdata_q};
            frm_bits_c = BIT_W'(40);
          end
          default: begin
            frm_word_c = {CMD_SE, addr_q, 8'h00};
            frm_bits_c = BIT_W'(32);
          end
        endcase
      end
      default: ;
    endcase
    poll_nxt_c = (poll_cnt == CNT_SAT) ? poll_cnt : poll_cnt + CNT_W'(1);
  end

  // Sequencer and SPI shift engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gap_next  <= S_IDLE;
      fphase    <= F_WAIT;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      gap_cnt   <= '0;
      poll_cnt  <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      sclk      <= 1'b0;
      cs        <= 1'b1;
      si        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (cs) gap_cnt <= (gap_cnt == CNT_SAT) ? gap_cnt : gap_cnt + CNT_W'(1);
      else    gap_cnt <= '0;

      if (frm_go_c) begin
        // CS falls with the first bit on SI; SCLK rises CLK_DIV cycles later
        state     <= frm_kind_c;
        fphase    <= F_LO;
        cs        <= 1'b0;
        sclk      <= 1'b0;
        si        <= frm_word_c[FRM_W-1];
        tx_sh     <= {frm_word_c[FRM_W-2:0], 1'b0};
        bits_left <= frm_bits_c - BIT_W'(1);
        div_cnt   <= DIV_LAST;
      end else if (fphase != F_WAIT) begin
        if (div_cnt != '0) begin
          div_cnt <= div_cnt - DIV_W'(1);
        end else begin
          div_cnt <= DIV_LAST;
          case (fphase)
            F_LO: begin
              sclk   <= 1'b1;
              rx_sh  <= {rx_sh[6:0], bus.so};
              fphase <= F_HI;
            end
            F_HI: begin
              // SI only moves on the edge where SCLK drops
              sclk <= 1'b0;
              if (bits_left == '0) begin
                si     <= 1'b0;
                fphase <= F_TAIL;
              end else begin
                si        <= tx_sh[FRM_W-1];
                tx_sh     <= {tx_sh[FRM_W-2:0], 1'b0};
                bits_left <= bits_left - BIT_W'(1);
                fphase    <= F_LO;
              end
            end
            F_TAIL: begin
              cs     <= 1'b1;
              fphase <= F_WAIT;
              case (state)
                S_WREN: begin
                  state    <= S_GAP;
                  gap_next <= S_XFER;
                end
                S_XFER: begin
                  if (op_q == 2'd0) begin
                    rdata <= rx_sh;
                    state <= S_FIN;
                  end else begin
                    state    <= S_GAP;
                    gap_next <= S_POLL;
                  end
                end
                S_POLL: begin
                  poll_cnt <= poll_nxt_c;
                  if (!rx_sh[0]) begin
                    err_q <= 1'b0;
                    state <= S_FIN;
                  end else if (poll_nxt_c >= POLL_LIM) begin
                    err_q <= 1'b1;
                    state <= S_FIN;
                  end else begin
                    state    <= S_GAP;
                    gap_next <= S_POLL;
                  end
                end
                default: state <= S_IDLE;
              endcase
            end
            default: fphase <= F_WAIT;
          endcase
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.req) begin
              op_q     <= bus.op;
              addr_q   <= bus.addr;
              wdata_q  <= bus.wdata;
              busy     <= 1'b1;
              poll_cnt <= '0;
              err_q    <= 1'b0;
              case (bus.op)
                2'd0:       state <= S_XFER;
                2'd1, 2'd2: state <= S_WREN;
                default: begin
                  err_q <= 1'b1;
                  state <= S_FIN;
                end
              endcase
            end
          end
          S_FIN: begin
            done  <= 1'b1;
            err   <= err_q;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.err   = err;
  assign bus.rdata = rdata;
  assign bus.sclk  = sclk;
  assign bus.cs    = cs;
  assign bus.si    = si;
  assign bus.wp    = 1'b1;
  assign bus.hold  = 1'b1;
endmodule

// File: tb/tb_flash_cmd_seq.sv
// Directed bench for flash_cmd_seq with a small SPI NOR flash model
// (4 KB sector 0, WREN/SE/PP/READ/RDSR) and a CLK-domain frame monitor.
module tb_flash_cmd_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic so_force;
  logic so_model = 1'b0;

  always #5 clk = ~clk;

  flash_cmd_seq_if bus ();

  flash_cmd_seq #(.CLK_DIV(2), .CS_GAP(4), .POLL_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_comb bus.so = so_force ? 1'b1 : so_model;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- flash model ----------------
  logic [7:0]  mem [4096];
  logic [7:0]  f_sh = 8'h00;
  logic [7:0]  f_cmd = 8'h00;
  logic [23:0] f_addr = 24'h0;
  logic [7:0]  f_data = 8'h00;
  int          f_b = 0;
  logic        wel = 1'b0;
  int          wip_left = 0;
  logic [7:0]  last_cmd = 8'h00;
  int          last_bits = 0;
  logic [23:0] last_addr = 24'h0;
  logic [7:0]  last_data = 8'h00;

  always @(posedge bus.sclk or posedge bus.cs) begin
    if (bus.cs) begin
      last_cmd  = f_cmd;
      last_bits = f_b;
      last_addr = f_addr;
      last_data = f_data;
      if (f_b == 8 && f_cmd == 8'h06) wel = 1'b1;
      else if (f_b == 32 && f_cmd == 8'h20 && wel) begin
        if (f_addr[23:12] == 12'h0) for (int i = 0; i < 4096; i++) mem[i] = 8'hFF;
        wip_left = 2;
        wel = 1'b0;
      end else if (f_b == 40 && f_cmd == 8'h02 && wel) begin
        if (f_addr[23:12] == 12'h0) mem[f_addr[11:0]] = mem[f_addr[11:0]] & f_data;
        wip_left = 1;
        wel = 1'b0;
      end else if (f_b == 16 && f_cmd == 8'h05 && wip_left > 0) wip_left--;
      f_b = 0;
    end else begin
      f_sh = {f_sh[6:0], bus.si};
      f_b++;
      if (f_b == 8) f_cmd = f_sh;
      if (f_b == 16 || f_b == 24 || f_b == 32) f_addr = {f_addr[15:0], f_sh};
      if (f_b == 40) f_data = f_sh;
    end
  end

  always @(negedge bus.sclk) begin
    logic [7:0] rd;
    logic [7:0] st;
    rd = (f_addr[23:12] == 12'h0) ? mem[f_addr[11:0]] : 8'hFF;
    st = {6'b0, wel, (wip_left > 0)};
    if (f_cmd == 8'h03 && f_b >= 32 && f_b < 40) so_model = rd[3'(39 - f_b)];
    else if (f_cmd == 8'h05 && f_b >= 8 && f_b < 16) so_model = st[3'(15 - f_b)];
    else so_model = 1'b0;
  end

  // ---------------- CLK-domain frame monitor ----------------
  typedef struct {
    logic [7:0]  cmd;
    int          bits;
    logic [23:0] addr;
    logic [7:0]  data;
    int          len;
    int          hi;
    int          first_hi;
    int          last_hi;
    int          gap;
  } frm_t;
  frm_t log_q[$];

  int   cur_len = 0, cur_hi = 0, cur_first = -1, cur_last = -1, cur_gap = 0;
  int   hi_run = 0, min_gap = 1000000;
  int   cs_falls = 0, sclk_rises = 0, si_viol = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_si = 1'b0;

  always @(negedge clk) begin
    if (bus.sclk && (bus.si !== prev_si)) si_viol++;
    if (bus.cs && bus.sclk) si_viol++;
    if (bus.sclk && !prev_sclk) sclk_rises++;
    if (!bus.cs) begin
      if (prev_cs) begin
        cs_falls++;
        cur_len = 0; cur_hi = 0; cur_first = -1; cur_last = -1;
        cur_gap = hi_run;
        if (hi_run < min_gap) min_gap = hi_run;
      end
      hi_run = 0;
      if (bus.sclk) begin
        if (cur_first < 0) cur_first = cur_len;
        cur_last = cur_len;
        cur_hi++;
      end
      cur_len++;
    end else begin
      if (!prev_cs)
        log_q.push_back('{last_cmd, last_bits, last_addr, last_data,
                          cur_len, cur_hi, cur_first, cur_last, cur_gap});
      hi_run++;
    end
    prev_cs = bus.cs;
    prev_sclk = bus.sclk;
    prev_si = bus.si;
  end

  // ---------------- host-side helpers ----------------
  task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.req = 1'b1; bus.op = op; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output logic e);
    logic got;
    got = 1'b0;
    e = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (bus.done) begin
        got = 1'b1;
        e = bus.err;
      end else @(negedge clk);
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic e;
    int   falls0, rises0;
    rst_n = 1'b0; so_force = 1'b0;
    bus.req = 1'b0; bus.op = 2'd0; bus.addr = 24'h0; bus.wdata = 8'h00;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h3C;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_status", {bus.busy, bus.done, bus.err}, 3'b000);
    chk("rst_spi", {bus.cs, bus.sclk, bus.si}, 3'b100);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("wp_hold", {bus.wp, bus.hold}, 2'b11);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // reserved opcode: DONE+ERR two cycles after REQ, no CS activity
    falls0 = cs_falls;
    bus.req = 1'b1; bus.op = 2'd3;
    @(negedge clk) bus.req = 1'b0;
    chk("op3_busy", {bus.busy, bus.done}, 2'b10);
    @(negedge clk);
    chk("op3_done_err", {bus.done, bus.err, bus.busy}, 3'b110);
    @(negedge clk);
    chk("op3_done_pulse", bus.done, 1'b0);
    chk("op3_cs_quiet", cs_falls, falls0);

    // sector erase at 0, with a stray request while busy
    log_q.delete();
    issue(2'd2, 24'h000000, 8'h00);
    chk("se_busy", bus.busy, 1'b1);
    repeat (20) @(negedge clk);
    bus.req = 1'b1; bus.op = 2'd0;
    @(negedge clk) bus.req = 1'b0;
    wait_done("se", 3000, e);
    chk("se_err", e, 1'b0);
    chk("se_frames", log_q.size(), 5);
    if (log_q.size() == 5) begin
      chk("wren_cmd", {log_q[0].cmd, 8'(log_q[0].bits)}, {8'h06, 8'd8});
      chk("wren_len", log_q[0].len, 34);
      chk("wren_sclk_hi", log_q[0].hi, 16);
      chk("wren_lead", log_q[0].first_hi, 2);
      chk("wren_tail", log_q[0].len - 1 - log_q[0].last_hi, 2);
      chk("se_cmd", {log_q[1].cmd, log_q[1].addr, 8'(log_q[1].bits)}, {8'h20, 24'h000000, 8'd32});
      chk("se_gap", log_q[1].gap, 4);
      for (int k = 2; k < 5; k++) begin
        chk("rdsr_cmd", {log_q[k].cmd, 8'(log_q[k].bits)}, {8'h05, 8'd16});
        chk("rdsr_gap", log_q[k].gap, 4);
      end
      chk("rdsr_len", log_q[3].len, 66);
    end

    // read back erased byte
    log_q.delete();
    issue(2'd0, 24'h000000, 8'h00);
    wait_done("rd0", 1000, e);
    chk("rd0_err", e, 1'b0);
    chk("rd0_rdata", bus.rdata, 8'hFF);
    chk("rd0_frames", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("rd0_cmd", {log_q[0].cmd, 8'(log_q[0].bits)}, {8'h03, 8'd40});
      chk("rd0_len", log_q[0].len, 162);
      chk("rd0_sclk_hi", log_q[0].hi, 80);
    end

    // program 0xA5 at 0x10 then read it and a neighbour back
    log_q.delete();
    issue(2'd1, 24'h000010, 8'hA5);
    wait_done("pp", 3000, e);
    chk("pp_err", e, 1'b0);
    chk("pp_frames", log_q.size(), 4);
    if (log_q.size() == 4)
      chk("pp_cmd", {log_q[1].cmd, log_q[1].addr, log_q[1].data}, {8'h02, 24'h000010, 8'hA5});
    issue(2'd0, 24'h000010, 8'h00);
    wait_done("rd10", 1000, e);
    chk("rd10_rdata", {e, bus.rdata}, {1'b0, 8'hA5});
    issue(2'd0, 24'h000011, 8'h00);
    wait_done("rd11", 1000, e);
    chk("rd11_rdata", bus.rdata, 8'hFF);

    // WIP stuck high: three polls then timeout
    so_force = 1'b1;
    log_q.delete();
    issue(2'd2, 24'h002000, 8'h00);
    wait_done("tmo", 3000, e);
    chk("tmo_err", e, 1'b1);
    chk("tmo_frames", log_q.size(), 5);
    if (log_q.size() == 5)
      chk("tmo_rdsr", {log_q[2].cmd, log_q[3].cmd, log_q[4].cmd}, {8'h05, 8'h05, 8'h05});
    so_force = 1'b0;

    // reset in the middle of the program address phase
    log_q.delete();
    issue(2'd1, 24'h000020, 8'h11);
    for (int i = 0; i < 300 && log_q.size() < 1; i++) @(negedge clk);
    chk("mid_wren_seen", log_q.size(), 1);
    for (int i = 0; i < 50 && bus.cs; i++) @(negedge clk);
    chk("mid_cs_low", bus.cs, 1'b0);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 8 && !bus.sclk; i++) @(negedge clk);
    chk("mid_sclk_hi", bus.sclk, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_async", {bus.cs, bus.sclk, bus.busy}, 3'b100);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    falls0 = cs_falls;
    rises0 = sclk_rises;
    repeat (50) @(negedge clk);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_cs_quiet", cs_falls, falls0);
    chk("post_rst_sclk_quiet", sclk_rises, rises0);
    issue(2'd0, 24'h000020, 8'h00);
    wait_done("rd20", 1000, e);
    chk("rd20_rdata", {e, bus.rdata}, {1'b0, 8'hFF});
    issue(2'd0, 24'h000010, 8'h00);
    wait_done("rd10b", 1000, e);
    chk("rd10b_rdata", bus.rdata, 8'hA5);

    // whole-run SPI timing properties
    chk("cs_gap_min", (min_gap >= 4), 1'b1);
    chk("si_stable", si_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
